// File: rtl/inst_resp_cancel_tracker_pkg.sv
// rtl/inst_resp_cancel_tracker_pkg.sv - shared CPU constants for the instruction fetch response tracker
package inst_resp_cancel_tracker_pkg;

    localparam int DEF_MAX_OUTST = 4;
    localparam int DEF_NUM_FLUSH = 2;
    localparam int FLUSH_WB_EX   = 0;
    localparam int FLUSH_BR      = 1;

    typedef enum logic [1:0] {
        RESP_NONE    = 2'd0,
        RESP_VALID   = 2'd1,
        RESP_DISCARD = 2'd2
    } resp_kind_e;

    function automatic int cnt_width(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/inst_resp_cancel_tracker_if.sv
// rtl/inst_resp_cancel_tracker_if.sv - instruction SRAM handshake and fetch response bundle
interface inst_resp_cancel_tracker_if;

    logic inst_sram_req;
    logic inst_sram_addr_ok;
    logic inst_sram_data_ok;
    logic req_allow;
    logic resp_valid;
    logic resp_discard;

    // master: fetch stage plus SRAM side; slave: the tracker
    modport master (
        output inst_sram_req,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        input  req_allow,
        input  resp_valid,
        input  resp_discard
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        output req_allow,
        output resp_valid,
        output resp_discard
    );

endinterface

// File: rtl/inst_resp_cancel_tracker_cnt.sv
// rtl/inst_resp_cancel_tracker_cnt.sv - saturating up/down counter with parallel load
module cpu_updown_cnt #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load wins; simultaneous inc and dec cancel out; both ends saturate
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && !dec && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/inst_resp_cancel_tracker.sv
// rtl/inst_resp_cancel_tracker.sv - tracks outstanding fetches and drops responses orphaned by a flush
module inst_resp_cancel_tracker
    import inst_resp_cancel_tracker_pkg::*;
#(
    parameter  int MAX_OUTST = DEF_MAX_OUTST,
    parameter  int NUM_FLUSH = DEF_NUM_FLUSH,
    localparam int CNT_W     = cnt_width(MAX_OUTST)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_FLUSH-1:0]     flush,
    inst_resp_cancel_tracker_if.slave sram,
    output logic                     cancel_pending,
    output logic [CNT_W-1:0]         outst_cnt,
    output logic [CNT_W-1:0]         cancel_cnt,
    output logic                     proto_err
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    logic             accept;
    logic             ret;
    logic             flush_any;
    logic [CNT_W-1:0] outst_nxt;
    logic [CNT_W-1:0] cancel_nxt;
    logic             proto_err_q;
    logic             proto_err_d;
    resp_kind_e       resp_kind;

    assign accept    = sram.inst_sram_req & sram.inst_sram_addr_ok;
    assign ret       = sram.inst_sram_data_ok;
    assign flush_any = |flush;

    always_comb begin
        resp_kind = RESP_NONE;
        if (ret) begin
            resp_kind = ((cancel_cnt != '0) || flush_any) ? RESP_DISCARD : RESP_VALID;
        end
    end

    assign sram.resp_valid   = (resp_kind == RESP_VALID);
    assign sram.resp_discard = (resp_kind == RESP_DISCARD);
    assign sram.req_allow    = (outst_cnt < MAX_C);
    assign cancel_pending    = (cancel_cnt != '0);

    cpu_updown_cnt #(
        .W   (CNT_W),
        .MAX (MAX_OUTST)
    ) u_outst_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (accept),
        .dec      (ret),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (outst_cnt),
        .cnt_nxt  (outst_nxt)
    );

    // a flush marks everything still in flight after this cycle as stale,
    // including a request accepted alongside the flush (it carries the old PC)
    cpu_updown_cnt #(
        .W   (CNT_W),
        .MAX (MAX_OUTST)
    ) u_cancel_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (1'b0),
        .dec      (sram.resp_discard),
        .load     (flush_any),
        .load_val (outst_nxt),
        .cnt      (cancel_cnt),
        .cnt_nxt  (cancel_nxt)
    );

    always_comb begin
        proto_err_d = proto_err_q;
        if ((ret && !accept && (outst_cnt == '0)) || (accept && (outst_cnt == MAX_C))) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

    logic unused_ok;
    assign unused_ok = ^cancel_nxt;

endmodule

// File: tb/tb_inst_resp_cancel_tracker.sv
// tb/tb_inst_resp_cancel_tracker.sv - vector table plus scoreboard bench for inst_resp_cancel_tracker
module tb_inst_resp_cancel_tracker;
    import inst_resp_cancel_tracker_pkg::*;

    localparam int CNT_W = 3;

    typedef struct {
        logic [1:0]  flush;
        logic        req;
        logic        aok;
        logic        dok;
        logic [10:0] exp;
    } vec_t;

    logic             clk;
    logic             resetn;
    logic [1:0]       flush;
    logic             cancel_pending;
    logic [CNT_W-1:0] outst_cnt;
    logic [CNT_W-1:0] cancel_cnt;
    logic             proto_err;

    int checks   = 0;
    int failures = 0;

    vec_t        vecs[$];
    logic [10:0] sb[$];

    inst_resp_cancel_tracker_if sram_if();

    inst_resp_cancel_tracker dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .sram           (sram_if.slave),
        .cancel_pending (cancel_pending),
        .outst_cnt      (outst_cnt),
        .cancel_cnt     (cancel_cnt),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp packing: {allow, valid, discard, pending, outst[2:0], cancel[2:0], perr}
    function automatic vec_t mk(input logic [1:0] f, input logic rq, input logic ak, input logic dk,
                                input logic al, input logic va, input logic di, input logic pe,
                                input int o, input int c, input logic er);
        vec_t v;
        v.flush = f;
        v.req   = rq;
        v.aok   = ak;
        v.dok   = dk;
        v.exp   = {al, va, di, pe, 3'(o), 3'(c), er};
        return v;
    endfunction

    function automatic logic [10:0] actual();
        return {sram_if.req_allow, sram_if.resp_valid, sram_if.resp_discard, cancel_pending,
                outst_cnt, cancel_cnt, proto_err};
    endfunction

    task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        flush                     = v.flush;
        sram_if.inst_sram_req     = v.req;
        sram_if.inst_sram_addr_ok = v.aok;
        sram_if.inst_sram_data_ok = v.dok;
        sb.push_back(v.exp);
        #2;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            check(nm, actual(), sb.pop_front());
        end
    endtask

    task automatic idle_inputs();
        flush                     = 2'b00;
        sram_if.inst_sram_req     = 1'b0;
        sram_if.inst_sram_addr_ok = 1'b0;
        sram_if.inst_sram_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();

        // three clean fetches
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 1, 0, 0, 3, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 1, 0, 0, 2, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // wb_ex flush with accept in the same cycle
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(2'b01, 1, 1, 0, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 3, 3, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 2, 2, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        // branch flush with a return in the same cycle
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(2'b10, 0, 0, 1, 1, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // second flush while cancelling reloads rather than accumulates
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(2'b01, 1, 1, 0, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 3, 3, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 1, 2, 2, 0));
        vecs.push_back(mk(2'b01, 0, 0, 0, 1, 0, 0, 1, 3, 2, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 1, 3, 3, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 3, 3, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 2, 2, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // flush with nothing in flight is ignored
        vecs.push_back(mk(2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // flush with accept and return together
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b01, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // fill to MAX_OUTST, then a forced overflow accept
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 1, 0, 1, 0, 0, 4, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 1, 0, 0, 3, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 1, 1, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

        repeat (2) @(negedge clk);
        #2;
        check("reset_state", actual(), 11'b1000_000_000_0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of a cancel window
        step(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1), "ar_acc0");
        step(mk(2'b00, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1), "ar_acc1");
        step(mk(2'b01, 1, 1, 0, 1, 0, 0, 0, 2, 0, 1), "ar_flush");
        step(mk(2'b00, 0, 0, 1, 1, 0, 1, 1, 3, 3, 1), "ar_ret");
        @(negedge clk);
        idle_inputs();
        #2;
        check("ar_before", actual(), 11'b1001_010_010_1);
        resetn = 1'b0;
        #1;
        check("ar_async", actual(), 11'b1000_000_000_0);
        @(negedge clk);
        resetn = 1'b1;

        // return with nothing outstanding
        step(mk(2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), "underflow_ret");
        step(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "underflow_err");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain leftover=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
